player_shot: RTL

Single player projectile for the space-invaders playfield. Launched from the player ship's nose, it climbs a fixed number of pixels per frame and tests its bounding box every cycle against one enemy's box. It issues a one-cycle hit pulse, which drives the enemy ship's `hit_i`, or retires silently at the top of the screen. One instance serves one enemy lane; the top level ORs or muxes lanes as needed.

---
 rtl/invaders_pkg.sv | 16 +
 rtl/counter.sv | 23 ++
 rtl/player_shot.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/invaders_pkg.sv
// rtl/invaders_pkg.sv - shared playfield types and constants for the invaders blocks
package invaders_pkg;

    typedef logic [9:0] pos_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [3:0] {
        SHOT_IDLE     = 4'b0001,
        SHOT_FLIGHT   = 4'b0010,
        SHOT_HIT      = 4'b0100,
        SHOT_COOLDOWN = 4'b1000
    } shot_state_e;

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - generic up counter with synchronous clear and enable
module counter #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(STEP);
        end
    end

endmodule

// File: rtl/player_shot.sv
// rtl/player_shot.sv - player projectile: launch, climb, collide with one enemy box
// Optional post-retire lockout enabled by defining PLAYER_SHOT_COOLDOWN_EN.
module player_shot
    import invaders_pkg::*;
#(
    parameter logic [11:0] color_p       = {4'hF, 4'h0, 4'h0},
    parameter pos_t        step_p        = 10'd8,
    parameter pos_t        shot_width_p  = 10'd2,
    parameter pos_t        shot_height_p = 10'd8,
    parameter logic [7:0]  cooldown_p    = 8'd15
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       frame_i,
    input  logic       fire_i,
    input  logic [9:0] player_center_i,
    input  logic [9:0] player_top_i,
    input  logic [9:0] enemy_left_i,
    input  logic [9:0] enemy_right_i,
    input  logic [9:0] enemy_top_i,
    input  logic [9:0] enemy_bot_i,
    input  logic       enemy_alive_i,
    output logic       hit_o,
    output logic       active_o,
    output logic [9:0] left_pos_o,
    output logic [9:0] right_pos_o,
    output logic [9:0] top_pos_o,
    output logic [9:0] bot_pos_o,
    output logic [3:0] shot_red_o,
    output logic [3:0] shot_green_o,
    output logic [3:0] shot_blue_o
);

`ifdef PLAYER_SHOT_COOLDOWN_EN
    localparam shot_state_e RETIRE_STATE = SHOT_COOLDOWN;
`else
    localparam shot_state_e RETIRE_STATE = SHOT_IDLE;
`endif

    shot_state_e state;
    shot_state_e state_next;

    pos_t left;
    pos_t top;
    pos_t right;
    pos_t bot;

    logic overlap;
    logic launch;
    logic climb;
    logic cool_done;

    assign right = left + shot_width_p - 10'd1;
    assign bot   = top + shot_height_p - 10'd1;

    // Inclusive box test; a dead enemy is transparent to the shot.
    always_comb begin
        overlap = enemy_alive_i
                  && (left  <= enemy_right_i)
                  && (right >= enemy_left_i)
                  && (top   <= enemy_bot_i)
                  && (bot   >= enemy_top_i);
    end

`ifdef PLAYER_SHOT_COOLDOWN_EN
    logic [7:0] cool_count;

    counter #(
        .WIDTH (8),
        .STEP  (1)
    ) u_cooldown (
        .clk    (clk_i),
        .rst_n  (reset_n_i),
        .clear  (state != SHOT_COOLDOWN),
        .enable (frame_i && (state == SHOT_COOLDOWN)),
        .count  (cool_count)
    );

    assign cool_done = (cooldown_p == 8'd0)
                       || (frame_i && (cool_count == cooldown_p - 8'd1));
`else
    assign cool_done = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= SHOT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SHOT_IDLE: begin
                if (fire_i && (player_top_i >= shot_height_p)) begin
                    state_next = SHOT_FLIGHT;
                end
            end
            SHOT_FLIGHT: begin
                if (overlap) begin
                    state_next = SHOT_HIT;
                end else if (frame_i && (top < step_p)) begin
                    state_next = RETIRE_STATE;
                end
            end
            SHOT_HIT: begin
                state_next = RETIRE_STATE;
            end
            SHOT_COOLDOWN: begin
                if (cool_done) begin
                    state_next = SHOT_IDLE;
                end
            end
            default: begin
                state_next = SHOT_IDLE;
            end
        endcase
    end

    always_comb begin
        hit_o    = (state == SHOT_HIT);
        active_o = (state == SHOT_FLIGHT);
    end

    assign launch = (state == SHOT_IDLE) && (state_next == SHOT_FLIGHT);
    // Overlap takes priority over the frame tick, so the shot freezes on a hit.
    assign climb  = (state == SHOT_FLIGHT) && !overlap && frame_i && (top >= step_p);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            left <= '0;
            top  <= '0;
        end else if (launch) begin
            left <= player_center_i - (shot_width_p >> 1);
            top  <= player_top_i - shot_height_p;
        end else if (climb) begin
            top <= top - step_p;
        end
    end

    assign left_pos_o   = left;
    assign right_pos_o  = right;
    assign top_pos_o    = top;
    assign bot_pos_o    = bot;
    assign shot_red_o   = color_p[11:8];
    assign shot_green_o = color_p[7:4];
    assign shot_blue_o  = color_p[3:0];

endmodule
